// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register: STAGES deep, with stall, flush and writeback mux.
// Define MEM_WB_PERF_EN to build the retired-instruction counter.
module mem_wb_pipe #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int STAGES = 1,
   parameter int CNT_W  = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [1:0]        WB,
   input  logic [DATA_W-1:0] Memout,
   input  logic [DATA_W-1:0] ALUOut,
   input  logic [REG_AW-1:0] RegRD,
   output logic              out_valid,
   output logic [1:0]        WBreg,
   output logic [DATA_W-1:0] Memreg,
   output logic [DATA_W-1:0] ALUreg,
   output logic [REG_AW-1:0] RegRDreg,
   output logic [DATA_W-1:0] wb_data,
   output logic              wb_we,
   output logic [CNT_W-1:0]  retire_cnt
);

   typedef struct packed {
      logic              valid;
      logic [1:0]        wb;
      logic [DATA_W-1:0] mem;
      logic [DATA_W-1:0] alu;
      logic [REG_AW-1:0] rd;
   } stage_t;

   stage_t r_stg [STAGES];
   stage_t w_in;
   stage_t w_last;

   assign w_in   = {in_valid, WB, Memout, ALUOut, RegRD};
   assign w_last = r_stg[STAGES-1];

   // Flush zeroes payload too, so a bubble presents WBreg = 0.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < STAGES; k++)
            r_stg[k] <= '0;
      end else if (flush) begin
         for (int k = 0; k < STAGES; k++)
            r_stg[k] <= '0;
      end else if (!stall) begin
         r_stg[0] <= w_in;
         for (int k = 1; k < STAGES; k++)
            r_stg[k] <= r_stg[k-1];
      end
   end

   assign out_valid = w_last.valid;
   assign WBreg     = w_last.wb;
   assign Memreg    = w_last.mem;
   assign ALUreg    = w_last.alu;
   assign RegRDreg  = w_last.rd;
   assign wb_data   = w_last.wb[0] ? w_last.mem : w_last.alu;
   assign wb_we     = w_last.valid & w_last.wb[1] & (|w_last.rd);

`ifdef MEM_WB_PERF_EN
   logic [CNT_W-1:0] r_cnt;

   // Counts instructions leaving the last stage on an advancing edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         r_cnt <= '0;
      else if (!flush && !stall && w_last.valid)
         r_cnt <= r_cnt + CNT_W'(1);
   end

   assign retire_cnt = r_cnt;
`else
   assign retire_cnt = '0;
`endif

endmodule
